// File: rtl/button_debouncer_if.sv
// Purpose: bundles the raw button input and the debounced level/press/release outputs.
// Latency: none, wiring only.
// Backpressure: none; the outputs are level and one-cycle pulse signals.
interface button_debouncer_if;
    logic btnIn;
    logic btnLevel;
    logic btnPress;
    logic btnRelease;

    // Button/stimulus side: drives the raw input and consumes the debounced outputs
    modport master (
        output btnIn,
        input  btnLevel,
        input  btnPress,
        input  btnRelease
    );

    // Debouncer side
    modport slave (
        input  btnIn,
        output btnLevel,
        output btnPress,
        output btnRelease
    );
endinterface

// File: rtl/button_debouncer.sv
// Purpose: synchronise and debounce a pushbutton; emit level plus press/release pulses.
// Latency: DEBOUNCE_CYCLES+3 edges from the first high sample to btnPress/btnLevel; release is symmetric.
// Backpressure: none; the pulses are fire-and-forget, one cycle wide.
// Optional feature: define BUTTON_DEBOUNCER_REPEAT_EN to re-pulse btnPress every REPEAT_CYCLES while held.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic               clk,
    input  logic               resetBtn,
    button_debouncer_if.slave  bus
);
    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] ARM_PRESS   = 2'd1;
    localparam logic [1:0] HELD        = 2'd2;
    localparam logic [1:0] ARM_RELEASE = 2'd3;

    logic             sync_meta;
    logic             sync;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept_press;
    logic             accept_release;
    logic             repeat_hit;
    logic             press_q;
    logic             release_q;
    logic             level_q;

    // Parameter sanity gate: an illegal value shows up as this named scope in the hierarchy.
    generate
        if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_out_of_range
        end
    endgenerate

    // Two-flop synchronizer; only the second stage is allowed to reach the FSM.
    always_ff @(posedge clk) begin
        if (resetBtn) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= bus.btnIn;
            sync      <= sync_meta;
        end
    end

    // Next-state and qualification counter; any disagreement during arming restarts from scratch.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        accept_press   = 1'b0;
        accept_release = 1'b0;
        case (state)
            IDLE: begin
                if (sync) begin
                    state_nxt = ARM_PRESS;
                    cnt_nxt   = '0;
                end
            end
            ARM_PRESS: begin
                if (!sync) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt    = HELD;
                    cnt_nxt      = '0;
                    accept_press = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!sync) begin
                    state_nxt = ARM_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            ARM_RELEASE: begin
                if (sync) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt      = IDLE;
                    cnt_nxt        = '0;
                    accept_release = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
    localparam int               RPT_W   = $clog2(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             staying_held;

    // A repeat only fires on a cycle that both starts and ends in HELD, so leaving wins.
    assign staying_held = (state == HELD) && (state_nxt == HELD);
    assign repeat_hit   = staying_held && (rpt_cnt == RPT_MAX);

    // Counts cycles spent in HELD; restarts at 0 on every entry and on each repeat.
    always_ff @(posedge clk) begin
        if (resetBtn) begin
            rpt_cnt <= '0;
        end else if (staying_held) begin
            rpt_cnt <= (rpt_cnt == RPT_MAX) ? '0 : rpt_cnt + 1'b1;
        end else begin
            rpt_cnt <= '0;
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    // State, counter and registered outputs; reset overrides even a same-edge acceptance.
    always_ff @(posedge clk) begin
        if (resetBtn) begin
            state     <= IDLE;
            cnt       <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            press_q   <= accept_press | repeat_hit;
            release_q <= accept_release;
            level_q   <= (state_nxt == HELD) || (state_nxt == ARM_RELEASE);
        end
    end

    assign bus.btnLevel   = level_q;
    assign bus.btnPress   = press_q;
    assign bus.btnRelease = release_q;
endmodule

// File: tb/tb_button_debouncer.sv
// Purpose: directed stimulus with a pulse scoreboard for button_debouncer (D=8, R=20).
// Latency: expected pulses are scheduled at drive cycle + 11.
// Backpressure: none.
module tb_button_debouncer;
    localparam int D = 8;
    localparam int R = 20;
    localparam int LAT = D + 3;

    typedef struct {
        bit rel;
        int cyc;
        bit lvl;
    } ev_t;

    logic clk;
    logic resetBtn;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    ev_t  exp_q[$];

    button_debouncer_if bus();

    button_debouncer #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk      (clk),
        .resetBtn (resetBtn),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input bit rel, input int at, input bit lvl);
        ev_t e;
        e.rel = rel;
        e.cyc = at;
        e.lvl = lvl;
        exp_q.push_back(e);
    endtask

    // Monitor: every pulse seen on the outputs is matched against the scoreboard head.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (bus.btnPress || bus.btnRelease) begin
                check("press_and_release_together", bus.btnPress & bus.btnRelease, 0);
                if (exp_q.size() == 0) begin
                    check("spurious_press", bus.btnPress, 0);
                    check("spurious_release", bus.btnRelease, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(e.rel ? "release_kind" : "press_kind", bus.btnRelease, e.rel);
                    check(e.rel ? "release_cycle" : "press_cycle", cyc, e.cyc);
                    check(e.rel ? "release_level" : "press_level", bus.btnLevel, e.lvl);
                end
            end
        end
    end

    initial begin
        int c;
        bus.btnIn = 1'b0;
        resetBtn  = 1'b1;
        tick(3);
        check("reset_level", bus.btnLevel, 0);
        check("reset_press", bus.btnPress, 0);
        check("reset_release", bus.btnRelease, 0);
        check("reset_state", dut.state, 0);
        resetBtn = 1'b0;
        tick(2);

        // Clean press, held 70 cycles past acceptance
        c = cyc;
        bus.btnIn = 1'b1;
        push(1'b0, c + LAT, 1'b1);
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
        push(1'b0, c + LAT + R, 1'b1);
        push(1'b0, c + LAT + 2 * R, 1'b1);
        push(1'b0, c + LAT + 3 * R, 1'b1);
`endif
        tick(LAT + 70);
        check("held_level", bus.btnLevel, 1);

        // Release: level stays up while arming, drops with the pulse
        c = cyc;
        bus.btnIn = 1'b0;
        push(1'b1, c + LAT, 1'b0);
        tick(5);
        check("arm_release_level", bus.btnLevel, 1);
        tick(10);
        check("released_level", bus.btnLevel, 0);
        check("released_state", dut.state, 0);

        // Bounce: high 5, low 1, high 5, low
        bus.btnIn = 1'b1; tick(5);
        bus.btnIn = 1'b0; tick(1);
        bus.btnIn = 1'b1; tick(5);
        bus.btnIn = 1'b0; tick(6);
        check("bounce_level_mid", bus.btnLevel, 0);
        tick(6);
        check("bounce_level", bus.btnLevel, 0);
        check("bounce_state", dut.state, 0);

        // Press, then a 3-cycle low glitch while held, then a real release
        c = cyc;
        bus.btnIn = 1'b1;
        push(1'b0, c + LAT, 1'b1);
        tick(20);
        bus.btnIn = 1'b0; tick(3);
        bus.btnIn = 1'b1; tick(5);
        check("glitch_level", bus.btnLevel, 1);
        check("glitch_state", dut.state, 2);
        c = cyc;
        bus.btnIn = 1'b0;
        push(1'b1, c + LAT, 1'b0);
        tick(15);
        check("glitch_release_level", bus.btnLevel, 0);

        // Reset at cnt=5 of ARM_PRESS with the button held
        c = cyc;
        bus.btnIn = 1'b1;
        tick(8);
        check("pre_reset_cnt", dut.cnt, 5);
        resetBtn = 1'b1;
        tick(1);
        check("midreset_level", bus.btnLevel, 0);
        check("midreset_press", bus.btnPress, 0);
        check("midreset_state", dut.state, 0);
        resetBtn = 1'b0;
        push(1'b0, cyc + LAT, 1'b1);
        tick(15);
        check("requalified_level", bus.btnLevel, 1);
        bus.btnIn = 1'b0;
        push(1'b1, cyc + LAT, 1'b0);
        tick(15);

        // Reset landing on the very edge that would accept the press
        c = cyc;
        bus.btnIn = 1'b1;
        tick(LAT - 1);
        resetBtn = 1'b1;
        tick(1);
        check("same_edge_reset_level", bus.btnLevel, 0);
        check("same_edge_reset_press", bus.btnPress, 0);
        resetBtn = 1'b0;
        push(1'b0, cyc + LAT, 1'b1);
        tick(15);
        bus.btnIn = 1'b0;
        push(1'b1, cyc + LAT, 1'b0);
        tick(15);

        tick(5);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning consecutive stable cycles required to accept a change (10 ms at 100 MHz); legal range 2 to 2^24.
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 25_000_000, meaning the held-button auto-repeat period in cycles (only used when the repeat feature is compiled in).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port resetBtn, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port btnIn, input, 1 bit: raw, asynchronous, bouncing pushbutton, active high.
REQ-006 The block SHALL have port btnLevel, output, 1 bit: debounced button level.
REQ-007 The block SHALL have port btnPress, output, 1 bit: one-cycle pulse per accepted press (and per repeat), driving the step/enable input of the downstream LED FSM stage.
REQ-008 The block SHALL have port btnRelease, output, 1 bit: one-cycle pulse per accepted release.

Function
REQ-009 btnIn SHALL pass through a two-flop synchronizer; only the second flop output (sync) feeds the FSM.
REQ-010 The FSM SHALL have states IDLE, ARM_PRESS, HELD and ARM_RELEASE.
REQ-011 IDLE: sync=1 -> ARM_PRESS with cnt=0; otherwise stay.
REQ-012 ARM_PRESS: sync=0 -> IDLE, cnt=0, with no output pulse; sync=1 and cnt=DEBOUNCE_CYCLES-1 -> HELD; otherwise cnt increments.
REQ-013 HELD: sync=0 -> ARM_RELEASE with cnt=0; otherwise stay.
REQ-014 ARM_RELEASE: sync=1 -> HELD, cnt=0, with no output pulse; sync=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE; otherwise cnt increments.
REQ-015 All outputs SHALL be registered; btnLevel=1 exactly while the state is HELD or ARM_RELEASE.
REQ-016 btnPress SHALL be high for exactly the one cycle following the ARM_PRESS->HELD transition edge.
REQ-017 btnRelease SHALL be high for exactly the one cycle following the ARM_RELEASE->IDLE transition edge.
REQ-018 Latency: with btnIn first sampled high at edge 1 and held stable, btnPress and btnLevel SHALL rise after edge DEBOUNCE_CYCLES+3; release SHALL be symmetric.
REQ-019 btnPress and btnRelease SHALL never both be high in the same cycle.
REQ-020 cnt width SHALL be $clog2(DEBOUNCE_CYCLES); cnt SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap).

Reset
REQ-021 resetBtn=1 at a clock edge SHALL force: sync flops=0, state=IDLE, cnt=0, repeat counter=0, btnLevel=0, btnPress=0, btnRelease=0.
REQ-022 Reset SHALL take priority over every transition, including a same-edge ARM_PRESS completion.
REQ-023 A reset mid-operation SHALL abandon any pending qualification; a button still held after reset SHALL be re-qualified in full and produce one btnPress.

Configuration
REQ-024 Macro BUTTON_DEBOUNCER_REPEAT_EN SHALL control auto-repeat.
REQ-025 With BUTTON_DEBOUNCER_REPEAT_EN defined: in HELD, a repeat counter (width $clog2(REPEAT_CYCLES)) SHALL start at 0 on entry; btnPress SHALL pulse additionally every REPEAT_CYCLES cycles spent in HELD; the counter SHALL clear on leaving HELD.
REQ-026 Without BUTTON_DEBOUNCER_REPEAT_EN: no repeat counter SHALL be synthesized and exactly one btnPress SHALL occur per accepted press; REPEAT_CYCLES SHALL be ignored.

Verification (DEBOUNCE_CYCLES=8, REPEAT_CYCLES=20 for simulation)
REQ-027 Clean press: btnIn 0->1 sampled at edge 1 and held -> btnPress=1 for one cycle after edge 11, btnLevel=1 from edge 11 on.
REQ-028 Bounce reject: btnIn high 5 cycles, low 1, high 5, low -> no btnPress, btnLevel stays 0, FSM returns to IDLE.
REQ-029 Release: after an accepted press, btnIn low and held -> btnRelease one cycle after 11 edges, btnLevel=0; a 3-cycle low glitch while held -> no btnRelease.
REQ-030 Reset mid-qualify: assert resetBtn for 1 cycle at cnt=5 of ARM_PRESS with btnIn held -> all outputs 0, then btnPress exactly 11 edges after reset deassertion.
REQ-031 Repeat (macro defined): hold button 70 cycles past acceptance -> btnPress pulses at acceptance and at +20, +40 and +60; macro undefined -> a single pulse only.
